// File: rtl/native_round_robin_arbiter.sv
// Round-robin arbiter sharing one native slave among N_MASTERS masters.
// A grant is locked from selection until the slave's ready pulse; one IDLE bubble between grants.
module native_round_robin_arbiter #(
  parameter int N_MASTERS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int SEL_W      = $clog2(N_MASTERS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_MASTERS-1:0]             m_valid,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0]  m_addr,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]  m_wdata,
  input  logic [N_MASTERS*STRB_WIDTH-1:0]  m_wstrb,
  output logic [N_MASTERS-1:0]             m_ready,
  output logic [DATA_WIDTH-1:0]            m_rdata,
  output logic                             s_valid,
  output logic [ADDR_WIDTH-1:0]            s_addr,
  output logic [DATA_WIDTH-1:0]            s_wdata,
  output logic [STRB_WIDTH-1:0]            s_wstrb,
  input  logic                             s_ready,
  input  logic [DATA_WIDTH-1:0]            s_rdata,
  output logic [SEL_W-1:0]                 grant,
  output logic                             busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  grant_q, grant_d;
  logic [SEL_W-1:0]  last_q, last_d;
  logic [SEL_W-1:0]  pick;
  logic              found;

  // Cyclic search starting just after the last completed grant.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      if (!found && m_valid[SEL_W'((int'(last_q) + i) % N_MASTERS)]) begin
        pick  = SEL_W'((int'(last_q) + i) % N_MASTERS);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (s_ready) begin
          last_d  = grant_q;
          state_d = IDLE;
        end else if (!m_valid[grant_q]) begin
          // Requester withdrew: drop the grant without advancing the pointer.
          state_d = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    s_valid = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    m_ready = '0;
    if (state_q == BUSY) begin
      s_valid          = m_valid[grant_q];
      m_ready[grant_q] = s_ready;
      for (int i = 0; i < N_MASTERS; i++) begin
        if (grant_q == SEL_W'(i)) begin
          s_addr  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          s_wdata = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
          s_wstrb = m_wstrb[i*STRB_WIDTH +: STRB_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= SEL_W'(N_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign m_rdata = s_rdata;
  assign grant   = grant_q;
  assign busy    = (state_q == BUSY);

endmodule

// File: tb/tb_native_round_robin_arbiter.sv
// Bench for native_round_robin_arbiter with four masters: vector table plus
// hand-written reset, fairness, wrap-around and abort sequences.
module tb_native_round_robin_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int SL = 2;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      m_valid;
  logic [N*AW-1:0]   m_addr;
  logic [N*DW-1:0]   m_wdata;
  logic [N*SW-1:0]   m_wstrb;
  logic [N-1:0]      m_ready;
  logic [DW-1:0]     m_rdata;
  logic              s_valid;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata;
  logic [SW-1:0]     s_wstrb;
  logic              s_ready;
  logic [DW-1:0]     s_rdata;
  logic [SL-1:0]     grant;
  logic              busy;

  native_round_robin_arbiter #(
    .N_MASTERS (N),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m_valid (m_valid),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_wstrb (m_wstrb),
    .m_ready (m_ready),
    .m_rdata (m_rdata),
    .s_valid (s_valid),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_wstrb (s_wstrb),
    .s_ready (s_ready),
    .s_rdata (s_rdata),
    .grant   (grant),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } exp_t;

  vec_t vecs[4];
  exp_t sb[$];
  int   gq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] base_addr(input int i);
    return 32'h1000 + 32'h100 * i;
  endfunction

  task automatic do_reset();
    rst_n   = 1'b0;
    m_valid = '0;
    s_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic load_addrs();
    for (int i = 0; i < N; i++) begin
      m_addr[i*AW +: AW]  = base_addr(i);
      m_wdata[i*DW +: DW] = 32'hA000_0000 + i;
      m_wstrb[i*SW +: SW] = 4'hF;
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t        e;
    logic [3:0]  onehot;
    onehot = 4'b0001 << v.m;
    @(posedge clk); #1;
    m_addr[v.m*AW +: AW]  = v.addr;
    m_wdata[v.m*DW +: DW] = v.wdata;
    m_wstrb[v.m*SW +: SW] = v.wstrb;
    m_valid = onehot;
    sb.push_back('{addr: v.addr, wdata: v.wdata, wstrb: v.wstrb});
    @(negedge clk);
    chk("vec_arb_cycle_svalid", s_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("vec_svalid_rise", s_valid, 1);
    chk("vec_grant", grant, v.m);
    for (int j = 1; j < v.lat; j++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("vec_wait_svalid", s_valid, 1);
      chk("vec_wait_mready", m_ready, 0);
    end
    @(posedge clk); #1;
    s_ready = 1'b1;
    s_rdata = v.rdata;
    @(negedge clk);
    chk("vec_mready", m_ready, onehot);
    chk("vec_mrdata", m_rdata, v.rdata);
    if (sb.size() == 0) begin
      chk("vec_sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("vec_saddr", s_addr, e.addr);
      chk("vec_swdata", s_wdata, e.wdata);
      chk("vec_swstrb", s_wstrb, e.wstrb);
    end
    @(posedge clk); #1;
    m_valid = '0;
    s_ready = 1'b0;
    @(negedge clk);
    chk("vec_svalid_fall", s_valid, 0);
    chk("vec_mready_once", m_ready, 0);
    chk("vec_busy_fall", busy, 0);
  endtask

  // Slave answers one cycle after s_valid rises; expected grants come from gq.
  task automatic run_rr(input logic [3:0] req, input int n_done);
    int   done;
    int   idle_run;
    int   cyc;
    int   e;
    logic sv;
    logic sr;
    done = 0; idle_run = 0; cyc = 0;
    @(posedge clk); #1;
    m_valid = req;
    while (done < n_done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      sv = s_valid;
      sr = s_ready;
      if (!sv) begin
        idle_run++;
      end else if (idle_run > 0) begin
        if (done > 0) chk("rr_bubble_len", idle_run, 1);
        idle_run = 0;
      end
      if (sv && sr) begin
        if (gq.size() == 0) begin
          chk("rr_queue_empty", 1, 0);
        end else begin
          e = gq.pop_front();
          chk("rr_grant", grant, e);
          chk("rr_mready", m_ready, 4'b0001 << e);
          chk("rr_saddr", s_addr, base_addr(e));
        end
        done++;
      end
      if (done < n_done) begin
        @(posedge clk); #1;
        s_ready = sv && !sr;
      end
    end
    if (done < n_done) begin
      checks++;
      errors++;
      $display("FAIL rr_timeout completions=%0d required=%0d", done, n_done);
    end
    @(posedge clk); #1;
    m_valid = '0;
    s_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{m: 1, addr: 32'h0000_0010, wdata: 32'hDEAD_BEEF, wstrb: 4'hF, rdata: 32'h0BAD_F00D, lat: 3};
    vecs[1] = '{m: 0, addr: 32'h0000_0020, wdata: 32'h0000_0000, wstrb: 4'h0, rdata: 32'h1234_5678, lat: 2};
    vecs[2] = '{m: 3, addr: 32'hFFFF_FFFC, wdata: 32'hA5A5_A5A5, wstrb: 4'h5, rdata: 32'hCAFE_F00D, lat: 1};
    vecs[3] = '{m: 2, addr: 32'h0000_0000, wdata: 32'hFFFF_FFFF, wstrb: 4'h8, rdata: 32'h8000_0001, lat: 1};

    rst_n   = 1'b0;
    s_ready = 1'b0;
    s_rdata = 32'h5555_AAAA;
    load_addrs();
    m_valid = 4'hF;

    // Reset values with every master requesting.
    repeat (2) @(negedge clk);
    chk("rst_svalid", s_valid, 0);
    chk("rst_mready", m_ready, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_saddr", s_addr, 0);
    chk("rst_mrdata", m_rdata, 32'h5555_AAAA);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_idle_busy", busy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rel_busy", busy, 1);
    chk("rel_grant", grant, 0);
    chk("rel_saddr", s_addr, base_addr(0));
    // Asynchronous reset between edges mid-transaction.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_svalid", s_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_mready", m_ready, 0);

    do_reset();
    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    do_reset();
    load_addrs();
    gq = '{0, 1, 2, 3, 0, 1};
    run_rr(4'b1111, 6);

    do_reset();
    gq = '{0, 2, 0};
    run_rr(4'b0101, 3);

    // Abort: master 1 withdraws mid-BUSY; pointer must stay at reset value.
    do_reset();
    @(posedge clk); #1 m_valid = 4'b0010;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_grant", grant, 1);
    chk("abort_busy", busy, 1);
    @(posedge clk); #1 m_valid = 4'b0000;
    @(negedge clk);
    chk("abort_svalid", s_valid, 0);
    chk("abort_mready", m_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_idle", busy, 0);
    gq = '{0};
    run_rr(4'b0101, 1);

    // s_ready in IDLE has no effect.
    @(posedge clk); #1 s_ready = 1'b1;
    @(negedge clk);
    chk("idle_sready_mready", m_ready, 0);
    @(posedge clk); #1 s_ready = 1'b0;
    @(negedge clk);
    chk("idle_sready_busy", busy, 0);
    chk("idle_sready_grant", grant, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
